ws2812b_line_decoder: RTL and testbench

- Receive-side counterpart of the WS2812B frame driver: samples a single-wire WS2812B NRZ line and decodes it into 24-bit GRB pixel words.
- Reports each pixel with its index in the frame, and signals frame end when the line stays low for the latch (reset) period.
- Used as a loopback checker on the LED line and as a pixel-emulation front end for chained designs.

---
 rtl/ws2812b_pkg.sv | 23 ++
 rtl/ws2812b_line_decoder_if.sv | 29 ++
 rtl/ws2812b_line_sync.sv | 40 ++++
 rtl/ws2812b_line_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ws2812b_line_decoder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B line timing, decoder defaults and decoder state encoding.
package ws2812b_pkg;

   // Line timing used by the matching frame driver, in clk cycles.
   localparam int unsigned BIT_PERIOD_CLKS   = 62;
   localparam int unsigned T1H_CLKS          = 39;
   localparam int unsigned T0H_CLKS          = 19;
   localparam int unsigned LATCH_CLKS        = 2600;

   localparam int unsigned MAX_POS_DEF       = 16;
   localparam int unsigned T1_MIN_CLKS_DEF   = 29;
   localparam int unsigned HIGH_MIN_CLKS_DEF = 8;
   localparam int unsigned HIGH_MAX_CLKS_DEF = 55;
   localparam int unsigned RESET_CLKS_DEF    = 1500;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_IDLE = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } dec_state_t;

endpackage

// File: rtl/ws2812b_line_decoder_if.sv
// Decoder-side signal bundle: raw line in, decoded pixel/frame reports out.
interface ws2812b_line_decoder_if
   import ws2812b_pkg::*;
#(
   parameter int unsigned MAX_POS = MAX_POS_DEF
);
   logic                         din;
   logic                         pixel_valid;
   logic [$clog2(MAX_POS)-1:0]   pixel_index;
   logic [7:0]                   green;
   logic [7:0]                   red;
   logic [7:0]                   blue;
   logic                         frame_done;
   logic [$clog2(MAX_POS+1)-1:0] pixel_count;
   logic                         err;
   logic                         overflow;

   modport master (
      input  din,
      output pixel_valid, pixel_index, green, red, blue,
      output frame_done, pixel_count, err, overflow
   );

   modport slave (
      output din,
      input  pixel_valid, pixel_index, green, red, blue,
      input  frame_done, pixel_count, err, overflow
   );
endinterface

// File: rtl/ws2812b_line_sync.sv
// Two-flop synchronizer for the asynchronous data line, with edge strobes
// registered so they line up with the first cycle of the new synchronized level.
module ws2812b_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s2,
   output logic rise,
   output logic fall
);
   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      rise_d = s1_q & ~s2_q;
      fall_d = ~s1_q & s2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign s2   = s2_q;
   assign rise = rise_q;
   assign fall = fall_q;
endmodule

// File: rtl/ws2812b_line_decoder.sv
// Decodes a WS2812B NRZ line into indexed 24-bit GRB pixels and frame-end reports.
// state | meaning
// SYNC  | waiting for a full low gap before trusting the line
// IDLE  | between frames, waiting for the first high pulse
// HIGH  | timing a high pulse
// LOW   | timing the low after a bit; a full gap ends the frame
module ws2812b_line_decoder
   import ws2812b_pkg::*;
#(
   parameter int unsigned MAX_POS       = MAX_POS_DEF,
   parameter int unsigned T1_MIN_CLKS   = T1_MIN_CLKS_DEF,
   parameter int unsigned HIGH_MIN_CLKS = HIGH_MIN_CLKS_DEF,
   parameter int unsigned HIGH_MAX_CLKS = HIGH_MAX_CLKS_DEF,
   parameter int unsigned RESET_CLKS    = RESET_CLKS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   ws2812b_line_decoder_if.master bus
);
   localparam int unsigned IDX_W = $clog2(MAX_POS);
   localparam int unsigned PIX_W = $clog2(MAX_POS + 1);
   localparam int unsigned HC_W  = $clog2(HIGH_MAX_CLKS + 2);
   localparam int unsigned LC_W  = $clog2(RESET_CLKS + 1);

   localparam logic [HC_W-1:0]  HIGH_MAX_C   = HC_W'(HIGH_MAX_CLKS);
   localparam logic [HC_W-1:0]  HIGH_MIN_C   = HC_W'(HIGH_MIN_CLKS);
   localparam logic [HC_W-1:0]  T1_MIN_C     = HC_W'(T1_MIN_CLKS);
   localparam logic [LC_W-1:0]  RESET_LAST_C = LC_W'(RESET_CLKS - 1);
   localparam logic [LC_W-1:0]  LOW_SAT_C    = LC_W'(RESET_CLKS);
   localparam logic [PIX_W-1:0] MAX_POS_C    = PIX_W'(MAX_POS);

   logic s2, rise, fall;

   ws2812b_line_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.din),
      .s2    (s2),
      .rise  (rise),
      .fall  (fall)
   );

   dec_state_t       state_q, state_d;
   logic [HC_W-1:0]  high_cnt_q, high_cnt_d;
   logic [LC_W-1:0]  low_cnt_q, low_cnt_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [22:0]      shift_q, shift_d;
   logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
   logic             pixel_valid_q, pixel_valid_d;
   logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
   logic [7:0]       green_q, green_d, red_q, red_d, blue_q, blue_d;
   logic             frame_done_q, frame_done_d;
   logic [PIX_W-1:0] pixel_count_q, pixel_count_d;
   logic             err_q, err_d;
   logic             overflow_q, overflow_d;
   logic [23:0]      word;

   always_comb begin
      state_d       = state_q;
      high_cnt_d    = high_cnt_q;
      low_cnt_d     = low_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      pix_idx_d     = pix_idx_q;
      pixel_valid_d = 1'b0;
      pixel_index_d = pixel_index_q;
      green_d       = green_q;
      red_d         = red_q;
      blue_d        = blue_q;
      frame_done_d  = 1'b0;
      pixel_count_d = pixel_count_q;
      err_d         = 1'b0;
      overflow_d    = overflow_q;
      word          = {shift_q, high_cnt_q >= T1_MIN_C};

      unique case (state_q)
         ST_SYNC: begin
            if (s2) begin
               low_cnt_d = '0;
            end else if (low_cnt_q == RESET_LAST_C) begin
               low_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               low_cnt_d = low_cnt_q + LC_W'(1);
            end
         end
         ST_IDLE: begin
            if (rise) begin
               high_cnt_d = HC_W'(1);
               state_d    = ST_HIGH;
            end
         end
         ST_HIGH: begin
            // A bad pulse drops the partial frame; decoding resumes after a full gap.
            if ((fall && high_cnt_q < HIGH_MIN_C) || (!fall && high_cnt_q == HIGH_MAX_C)) begin
               err_d     = 1'b1;
               low_cnt_d = '0;
               bit_cnt_d = '0;
               pix_idx_d = '0;
               shift_d   = '0;
               state_d   = ST_SYNC;
            end else if (fall) begin
               shift_d   = word[22:0];
               low_cnt_d = LC_W'(1);
               state_d   = ST_LOW;
               if (bit_cnt_q == 5'd23) begin
                  bit_cnt_d = '0;
                  if (pix_idx_q < MAX_POS_C) begin
                     pixel_valid_d = 1'b1;
                     pixel_index_d = pix_idx_q[IDX_W-1:0];
                     green_d       = word[23:16];
                     red_d         = word[15:8];
                     blue_d        = word[7:0];
                     pix_idx_d     = pix_idx_q + PIX_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end else begin
               high_cnt_d = high_cnt_q + HC_W'(1);
            end
         end
         ST_LOW: begin
            if (rise) begin
               high_cnt_d = HC_W'(1);
               state_d    = ST_HIGH;
            end else if (low_cnt_q == RESET_LAST_C) begin
               frame_done_d  = 1'b1;
               pixel_count_d = pix_idx_q;
               err_d         = (bit_cnt_q != 5'd0);
               bit_cnt_d     = '0;
               pix_idx_d     = '0;
               shift_d       = '0;
               overflow_d    = 1'b0;
               low_cnt_d     = '0;
               state_d       = ST_IDLE;
            end else if (low_cnt_q != LOW_SAT_C) begin
               low_cnt_d = low_cnt_q + LC_W'(1);
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_SYNC;
         high_cnt_q    <= '0;
         low_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         pix_idx_q     <= '0;
         pixel_valid_q <= 1'b0;
         pixel_index_q <= '0;
         green_q       <= '0;
         red_q         <= '0;
         blue_q        <= '0;
         frame_done_q  <= 1'b0;
         pixel_count_q <= '0;
         err_q         <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         high_cnt_q    <= high_cnt_d;
         low_cnt_q     <= low_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         pix_idx_q     <= pix_idx_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_index_q <= pixel_index_d;
         green_q       <= green_d;
         red_q         <= red_d;
         blue_q        <= blue_d;
         frame_done_q  <= frame_done_d;
         pixel_count_q <= pixel_count_d;
         err_q         <= err_d;
         overflow_q    <= overflow_d;
      end
   end

   assign bus.pixel_valid = pixel_valid_q;
   assign bus.pixel_index = pixel_index_q;
   assign bus.green       = green_q;
   assign bus.red         = red_q;
   assign bus.blue        = blue_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.pixel_count = pixel_count_q;
   assign bus.err         = err_q;
   assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ws2812b_line_decoder.sv
// Directed bench for the WS2812B line decoder: table of single-pixel frames
// plus hand-written multi-cycle sequences for overflow, errors and reset.
module tb_ws2812b_line_decoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ws2812b_line_decoder_if #(.MAX_POS(16)) bus ();

   ws2812b_line_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0]  idx;
      logic [23:0] grb;
   } pix_t;

   typedef struct {
      logic [23:0] word;
      int          hi1, lo1, hi0, lo0;
      logic [23:0] exp;
   } vec_t;

   pix_t        pix_q[$];
   int          fd_cnt = 0;
   int          err_cnt = 0;
   logic [4:0]  fd_count_last = '0;
   logic        fd_err_last = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.pixel_valid) pix_q.push_back({bus.pixel_index, bus.green, bus.red, bus.blue});
         if (bus.frame_done) begin
            fd_cnt++;
            fd_count_last = bus.pixel_count;
            fd_err_last   = bus.err;
         end
         if (bus.err) err_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic hold_low(input int n);
      bus.din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [23:0] w, input int nbits,
                            input int hi1, input int lo1, input int hi0, input int lo0);
      for (int i = 23; i > 23 - nbits; i--) begin
         bus.din = 1'b1;
         repeat (w[i] ? hi1 : hi0) @(negedge clk);
         bus.din = 1'b0;
         repeat (w[i] ? lo1 : lo0) @(negedge clk);
      end
   endtask

   task automatic send_std(input logic [23:0] w);
      send_bits(w, 24, 39, 23, 19, 43);
   endtask

   task automatic send_fast(input logic [23:0] w);
      send_bits(w, 24, 30, 8, 10, 8);
   endtask

   function automatic logic [23:0] pat(input int n);
      logic [7:0] b;
      b = 8'(n);
      return {b, ~b, b ^ 8'h55};
   endfunction

   vec_t vecs[6];
   int   fd0, err0;
   pix_t p;

   initial begin
      vecs[0] = '{24'hA53C0F, 39, 23, 19, 43, 24'hA53C0F};
      vecs[1] = '{24'h5A00FF, 39, 23, 19, 43, 24'h5A00FF};
      vecs[2] = '{24'hFFFFFF, 28, 10, 19, 10, 24'h000000};
      vecs[3] = '{24'h000000, 39, 10, 29, 10, 24'hFFFFFF};
      vecs[4] = '{24'h123456, 29, 20, 28, 20, 24'h123456};
      vecs[5] = '{24'hC3C3C3, 55, 10,  8, 10, 24'hC3C3C3};

      bus.din = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_pixel_valid", 32'(bus.pixel_valid), 0);
      check("rst_frame_done", 32'(bus.frame_done), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      check("rst_fields", {bus.green, bus.red, bus.blue}, 0);
      check("rst_pixel_count", 32'(bus.pixel_count), 0);
      reset = 1'b0;
      hold_low(1600);

      // Single-pixel frames including bit-decision and pulse-width boundaries.
      for (int v = 0; v < 6; v++) begin
         pix_q.delete();
         fd0 = fd_cnt; err0 = err_cnt;
         send_bits(vecs[v].word, 24, vecs[v].hi1, vecs[v].lo1, vecs[v].hi0, vecs[v].lo0);
         hold_low(v == 0 ? 2600 : 1700);
         check($sformatf("vec%0d_npix", v), pix_q.size(), 1);
         if (pix_q.size() == 1) begin
            check($sformatf("vec%0d_idx", v), 32'(pix_q[0].idx), 0);
            check($sformatf("vec%0d_grb", v), 32'(pix_q[0].grb), 32'(vecs[v].exp));
         end
         check($sformatf("vec%0d_fd", v), fd_cnt - fd0, 1);
         check($sformatf("vec%0d_count", v), 32'(fd_count_last), 1);
         check($sformatf("vec%0d_err", v), err_cnt - err0, 0);
      end

      // Full 16-pixel frame.
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      for (int n = 0; n < 16; n++) send_fast(pat(n));
      check("f16_overflow_before_gap", 32'(bus.overflow), 0);
      hold_low(1700);
      check("f16_npix", pix_q.size(), 16);
      for (int n = 0; n < 16 && n < pix_q.size(); n++) begin
         p = pix_q[n];
         check($sformatf("f16_idx%0d", n), 32'(p.idx), 32'(n));
         check($sformatf("f16_grb%0d", n), 32'(p.grb), 32'(pat(n)));
      end
      check("f16_fd", fd_cnt - fd0, 1);
      check("f16_count", 32'(fd_count_last), 16);
      check("f16_overflow", 32'(bus.overflow), 0);
      check("f16_err", err_cnt - err0, 0);

      // 17-pixel frame: last one is dropped and flagged.
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      for (int n = 0; n < 16; n++) send_fast(pat(n + 32));
      check("f17_overflow_pre", 32'(bus.overflow), 0);
      send_fast(24'h777777);
      check("f17_overflow_set", 32'(bus.overflow), 1);
      hold_low(1700);
      check("f17_npix", pix_q.size(), 16);
      if (pix_q.size() == 16) check("f17_last_grb", 32'(pix_q[15].grb), 32'(pat(47)));
      check("f17_fd", fd_cnt - fd0, 1);
      check("f17_count", 32'(fd_count_last), 16);
      check("f17_overflow_clr", 32'(bus.overflow), 0);
      check("f17_err", err_cnt - err0, 0);

      // Partial word at frame end.
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      send_bits(24'hB6D000, 10, 39, 23, 19, 43);
      hold_low(2600);
      check("part_npix", pix_q.size(), 0);
      check("part_fd", fd_cnt - fd0, 1);
      check("part_count", 32'(fd_count_last), 0);
      check("part_err_with_fd", 32'(fd_err_last), 1);
      check("part_err_cnt", err_cnt - err0, 1);
      send_std(24'h0F1E2D);
      hold_low(1700);
      check("part_next_npix", pix_q.size(), 1);
      if (pix_q.size() == 1) begin
         check("part_next_idx", 32'(pix_q[0].idx), 0);
         check("part_next_grb", 32'(pix_q[0].grb), 32'h0F1E2D);
      end

      // Short glitch mid-pixel, trailing bits ignored until a full gap.
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      send_bits(24'hFF0000, 6, 39, 23, 19, 43);
      bus.din = 1'b1; repeat (5) @(negedge clk);
      bus.din = 1'b0; repeat (20) @(negedge clk);
      send_bits(24'hAAAAAA, 8, 39, 23, 19, 43);
      check("glitch_err", err_cnt - err0, 1);
      hold_low(1600);
      send_std(24'h112233);
      hold_low(1700);
      check("glitch_npix", pix_q.size(), 1);
      if (pix_q.size() == 1) begin
         check("glitch_idx", 32'(pix_q[0].idx), 0);
         check("glitch_grb", 32'(pix_q[0].grb), 32'h112233);
      end
      check("glitch_fd", fd_cnt - fd0, 1);
      check("glitch_err_total", err_cnt - err0, 1);

      // Overlong high pulse mid-pixel.
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      send_bits(24'h0F0F0F, 12, 39, 23, 19, 43);
      bus.din = 1'b1; repeat (60) @(negedge clk);
      bus.din = 1'b0; repeat (40) @(negedge clk);
      send_bits(24'hFFFFFF, 5, 39, 23, 19, 43);
      check("long_err", err_cnt - err0, 1);
      check("long_npix_before", pix_q.size(), 0);
      hold_low(1600);
      send_std(24'h80FE01);
      hold_low(1700);
      check("long_npix", pix_q.size(), 1);
      if (pix_q.size() == 1) begin
         check("long_idx", 32'(pix_q[0].idx), 0);
         check("long_grb", 32'(pix_q[0].grb), 32'h80FE01);
      end
      check("long_fd", fd_cnt - fd0, 1);

      // Reset during bit 12 of pixel 3 while the line keeps toggling.
      pix_q.delete();
      for (int n = 0; n < 3; n++) send_std(pat(n + 100));
      check("rstmid_npix_pre", pix_q.size(), 3);
      send_bits(24'hFFFFFF, 11, 39, 23, 19, 43);
      bus.din = 1'b1; repeat (10) @(negedge clk);
      reset = 1'b1; repeat (3) @(negedge clk);
      reset = 1'b0;
      pix_q.delete(); fd0 = fd_cnt; err0 = err_cnt;
      repeat (26) @(negedge clk);
      bus.din = 1'b0; repeat (23) @(negedge clk);
      send_bits(24'hFFFFFF, 12, 39, 23, 19, 43);
      send_std(24'h445566);
      hold_low(2600);
      check("rstmid_npix", pix_q.size(), 0);
      check("rstmid_fd", fd_cnt - fd0, 0);
      send_std(24'h9ABCDE);
      hold_low(1700);
      check("rstmid_next_npix", pix_q.size(), 1);
      if (pix_q.size() == 1) begin
         check("rstmid_next_idx", 32'(pix_q[0].idx), 0);
         check("rstmid_next_grb", 32'(pix_q[0].grb), 32'h9ABCDE);
      end
      check("rstmid_next_fd", fd_cnt - fd0, 1);
      check("rstmid_next_count", 32'(fd_count_last), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
